// File: rtl/seg_scan_driver.sv
// seg_scan_driver: two-digit sign/magnitude 7-segment scan stage.
// Define SEG_OVF_BLINK_EN to blink both digits while overflow is shown.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] value_in,
    input  logic       ovf,
    output logic       ready,
    output logic [6:0] seg,
    output logic       an3,
    output logic       an4,
    output logic [3:0] value_q
);

    localparam int MAXL = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    localparam logic [CW-1:0] DIG_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = (GUARD > 0) ? CW'(GUARD - 1) : '0;

    localparam logic [1:0] ST_GAP_M    = 2'd0;
    localparam logic [1:0] ST_DIG_MAG  = 2'd1;
    localparam logic [1:0] ST_GAP_S    = 2'd2;
    localparam logic [1:0] ST_DIG_SIGN = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    logic [CW-1:0] presc_q, presc_d;
    logic [1:0]    state_q, state_d;
    logic          tick;
    logic          boundary;

    logic [3:0] shown_q, shown_d;
    logic [3:0] pend_q, pend_d;
    logic       pv_q, pv_d;
    logic [3:0] mag;

    logic [6:0] seg_q, seg_d;
    logic       an3_q, an3_d;
    logic       an4_q, an4_d;
    logic       ready_q, ready_d;
    logic [3:0] disp_q, disp_d;
    logic       blank_all;

    function automatic logic [6:0] glyph(input logic [3:0] m);
        logic [6:0] g;
        case (m)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Prescaler and scan sequencer; zero-length guard gaps are skipped.
    always_comb begin
        logic [CW-1:0] last;
        last = (state_q == ST_GAP_M || state_q == ST_GAP_S)
             ? GAP_LAST : DIG_LAST;
        tick     = (presc_q == last);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        state_d  = state_q;
        boundary = tick && (state_q == ST_DIG_SIGN);
        if (tick) begin
            case (state_q)
                ST_GAP_M:   state_d = ST_DIG_MAG;
                ST_DIG_MAG: state_d = (GUARD == 0) ? ST_DIG_SIGN : ST_GAP_S;
                ST_GAP_S:   state_d = ST_DIG_SIGN;
                default:    state_d = (GUARD == 0) ? ST_DIG_MAG : ST_GAP_M;
            endcase
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            state_q <= ST_GAP_M;
        end else begin
            presc_q <= presc_d;
            state_q <= state_d;
        end
    end

    // Load handshake: stage off-boundary loads, promote them at the frame edge.
    always_comb begin
        shown_d = shown_q;
        pend_d  = pend_q;
        pv_d    = pv_q;
        if (boundary) begin
            if (load) begin
                shown_d = value_in;
                pv_d    = 1'b0;
            end else if (pv_q) begin
                shown_d = pend_q;
                pv_d    = 1'b0;
            end
        end else if (load) begin
            pend_d = value_in;
            pv_d   = 1'b1;
        end
    end

    // Shown and pending value registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shown_q <= 4'd0;
            pend_q  <= 4'd0;
            pv_q    <= 1'b0;
        end else begin
            shown_q <= shown_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
        end
    end

`ifdef SEG_OVF_BLINK_EN
    logic       pend_ovf_q, pend_ovf_d;
    logic       shown_ovf_q, shown_ovf_d;
    logic [4:0] fcnt_q, fcnt_d;

    // Overflow flag follows its value; frame counter only runs while shown.
    always_comb begin
        pend_ovf_d  = pend_ovf_q;
        shown_ovf_d = shown_ovf_q;
        fcnt_d      = fcnt_q;
        if (boundary) begin
            if (load) begin
                shown_ovf_d = ovf;
            end else if (pv_q) begin
                shown_ovf_d = pend_ovf_q;
            end
        end else if (load) begin
            pend_ovf_d = ovf;
        end
        if (!shown_ovf_q) begin
            fcnt_d = 5'd0;
        end else if (boundary) begin
            fcnt_d = fcnt_q + 5'd1;
        end
    end

    // Overflow and blink counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_ovf_q  <= 1'b0;
            shown_ovf_q <= 1'b0;
            fcnt_q      <= 5'd0;
        end else begin
            pend_ovf_q  <= pend_ovf_d;
            shown_ovf_q <= shown_ovf_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign blank_all = fcnt_q[4];
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign blank_all  = 1'b0;
`endif

    assign mag = shown_q[3] ? (~shown_q + 4'd1) : shown_q;

    // Pin values decoded from the current scan slot and shown value.
    always_comb begin
        seg_d   = SEG_BLANK;
        an3_d   = 1'b1;
        an4_d   = 1'b1;
        ready_d = ~pv_q;
        disp_d  = shown_q;
        case (state_q)
            ST_DIG_MAG: begin
                an4_d = 1'b0;
                seg_d = glyph(mag);
            end
            ST_DIG_SIGN: begin
                an3_d = 1'b0;
                seg_d = shown_q[3] ? SEG_MINUS : SEG_BLANK;
            end
            default: begin
                seg_d = SEG_BLANK;
            end
        endcase
        if (blank_all) begin
            an3_d = 1'b1;
            an4_d = 1'b1;
        end
    end

    // Output pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q   <= SEG_BLANK;
            an3_q   <= 1'b1;
            an4_q   <= 1'b1;
            ready_q <= 1'b1;
            disp_q  <= 4'd0;
        end else begin
            seg_q   <= seg_d;
            an3_q   <= an3_d;
            an4_q   <= an4_d;
            ready_q <= ready_d;
            disp_q  <= disp_d;
        end
    end

    assign seg     = seg_q;
    assign an3     = an3_q;
    assign an4     = an4_q;
    assign ready   = ready_q;
    assign value_q = disp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver.
// Reference model works from frame position and load rules only.
module tb_seg_scan_driver;

    localparam int RD    = 4;
    localparam int G     = 1;
    localparam int FRAME = 2 * G + 2 * RD;

    typedef struct packed {
        logic [6:0] seg;
        logic       an3;
        logic       an4;
        logic       ready;
        logic [3:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] value_in;
    logic       ovf;
    logic       ready;
    logic [6:0] seg;
    logic       an3;
    logic       an4;
    logic [3:0] value_q;

    int vectors;
    int miscompares;

    exp_t sbq[$];
    exp_t mon_e;

    logic [6:0] glyph_tab [0:8];

    int         mc;
    logic [3:0] m_shown;
    logic [3:0] m_pend;
    bit         m_pv;

    seg_scan_driver #(
        .REFRESH_DIV(RD),
        .GUARD(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value_in(value_in),
        .ovf(ovf),
        .ready(ready),
        .seg(seg),
        .an3(an3),
        .an4(an4),
        .value_q(value_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input exp_t e);
        vectors++;
        if (seg !== e.seg || an3 !== e.an3 || an4 !== e.an4 ||
            ready !== e.ready || value_q !== e.val) begin
            miscompares++;
            $display("FAIL %s t=%0t got/want seg=%b/%b an3=%b/%b an4=%b/%b ready=%b/%b value_q=%b/%b",
                     nm, $time, seg, e.seg, an3, e.an3, an4, e.an4,
                     ready, e.ready, value_q, e.val);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.seg   = 7'h7F;
        e.an3   = 1'b1;
        e.an4   = 1'b1;
        e.ready = 1'b1;
        e.val   = 4'd0;
        return e;
    endfunction

    // Pins driven in the cycle after the one the model currently describes.
    function automatic exp_t expect_now();
        exp_t e;
        int p;
        int sv;
        int m;
        p  = mc % FRAME;
        sv = (m_shown[3]) ? int'(m_shown) - 16 : int'(m_shown);
        m  = (sv < 0) ? -sv : sv;
        e.seg   = 7'h7F;
        e.an3   = 1'b1;
        e.an4   = 1'b1;
        e.ready = !m_pv;
        e.val   = m_shown;
        if (p >= G && p < G + RD) begin
            e.an4 = 1'b0;
            e.seg = glyph_tab[m];
        end else if (p >= 2 * G + RD) begin
            e.an3 = 1'b0;
            e.seg = (sv < 0) ? 7'b0111111 : 7'h7F;
        end
        return e;
    endfunction

    function automatic void model_apply(input logic ld, input logic [3:0] v);
        bit edge_now;
        edge_now = ((mc % FRAME) == FRAME - 1);
        if (ld) begin
            if (edge_now) begin
                m_shown = v;
                m_pv    = 0;
            end else begin
                m_pend = v;
                m_pv   = 1;
            end
        end else if (edge_now && m_pv) begin
            m_shown = m_pend;
            m_pv    = 0;
        end
        mc++;
    endfunction

    function automatic void model_reset();
        mc      = 0;
        m_shown = 4'd0;
        m_pend  = 4'd0;
        m_pv    = 0;
    endfunction

    task automatic step(input logic ld, input logic [3:0] v);
        exp_t e;
        load     = ld;
        value_in = v;
        ovf      = 1'($urandom_range(0, 1));
        e = expect_now();
        model_apply(ld, v);
        @(posedge clk);
        #1;
        load = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0);
    endtask

    task automatic run_to_phase(input int p);
        while ((mc % FRAME) != p) step(1'b0, 4'h0);
    endtask

    // Monitor: every pushed expectation is compared at the next falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                check("scan", mon_e);
            end
        end
    end

    initial begin
        glyph_tab[0] = 7'b1000000;
        glyph_tab[1] = 7'b1111001;
        glyph_tab[2] = 7'b0100100;
        glyph_tab[3] = 7'b0110000;
        glyph_tab[4] = 7'b0011001;
        glyph_tab[5] = 7'b0010010;
        glyph_tab[6] = 7'b0000010;
        glyph_tab[7] = 7'b1111000;
        glyph_tab[8] = 7'b0000000;
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b0;
        load     = 1'b0;
        value_in = 4'h0;
        ovf      = 1'b0;
        model_reset();
        #12;
        check("reset", reset_exp());
        rst = 1'b1;

        idle(25);

        run_to_phase(2);
        step(1'b1, 4'b1011);
        idle(20);

        run_to_phase(3);
        step(1'b1, 4'b1000);
        idle(20);

        run_to_phase(1);
        step(1'b1, 4'b0011);
        idle(3);
        step(1'b1, 4'b0110);
        idle(20);

        run_to_phase(FRAME - 1);
        step(1'b1, 4'b0111);
        idle(20);

        run_to_phase(2);
        step(1'b1, 4'b0101);
        run_to_phase(2 * G + RD + 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_mid_scan", reset_exp());
        model_reset();
        #1;
        rst = 1'b1;
        idle(25);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                step(1'b1, 4'($urandom_range(0, 15)));
            end else begin
                step(1'b0, 4'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d want=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Display back-end stage fed by the two's-complement core.
- Latches a 4-bit signed result with a load strobe and converts it to sign/magnitude.
- Time-multiplexes two common-anode 7-segment digits: an3 = sign digit, an4 = magnitude digit.
- Updates the shown value only at frame boundaries, so a digit never shows a torn or partial value.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is enabled per scan slot. Minimum 2.
- GUARD, 2: clock cycles both anodes are forced off between slots, for anti-ghosting. 0 is allowed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe; capture value_in
- value_in  in  4  two's-complement value, range -8..+7
- ovf  in  1  overflow flag from upstream; used only with the optional feature
- ready  out  1  high when no update is pending
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an3  out  1  sign digit enable, active-low
- an4  out  1  magnitude digit enable, active-low
- value_q  out  4  value currently displayed (two's complement)

Behaviour:
- Reset (rst low, asynchronous):
  - prescaler = 0, state = GAP_M, shown = 0, pending = 0, pend_valid = 0.
  - seg = 7'h7F, an3 = an4 = 1, ready = 1, value_q = 0.
- All outputs are registered (one-cycle pipeline from state to pins).
- Prescaler:
  - Counts 0..L-1 in each state, where L = GUARD for GAP states and REFRESH_DIV for DIG states.
  - A tick occurs at L-1; the counter returns to 0 and the state advances.
  - A GAP state with GUARD = 0 is skipped entirely.
- State cycle: GAP_M -> DIG_MAG -> GAP_S -> DIG_SIGN -> GAP_M.
  - GAP_*: an3 = an4 = 1, seg = 7'h7F.
  - DIG_MAG: an4 = 0, an3 = 1, seg = glyph(mag).
  - DIG_SIGN: an3 = 0, an4 = 1, seg = 7'b0111111 ("-") if shown[3] is set, else 7'h7F (blank).
- Frame boundary: the tick that leaves DIG_SIGN.
- Magnitude:
  - neg = shown[3]; mag = neg ? (~shown + 1) : shown, computed as 4-bit unsigned.
  - -8 (4'b1000) yields mag = 8; there is no overflow in this conversion.
- Glyphs (active-low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000
  - Any other code = 7'h7F.
- Load handshake:
  - load = 1 off-boundary: pending <= value_in, pend_valid <= 1. A later load before the boundary overwrites pending (last value wins).
  - At the frame boundary with pend_valid = 1: shown <= pending, pend_valid <= 0.
  - load coincident with the boundary: shown <= value_in directly, pend_valid <= 0. Any older pending value is discarded.
  - ready = ~pend_valid, registered.
  - value_q = shown.
- Reset mid-scan: immediately blanks both digits and drops pending data; scanning restarts at GAP_M.

Optional Feature:
- Macro: SEG_OVF_BLINK_EN.
- Defined:
  - ovf is sampled with load, stored with the value, and promoted to the shown value at the boundary.
  - While the shown ovf bit = 1, a 5-bit frame counter increments each frame boundary.
  - While that counter's MSB = 1, both anodes are held at 1 (about 50% blink).
  - The frame counter resets to 0.
- Undefined:
  - ovf is ignored; no frame counter is implemented.
  - Behaviour is identical to the defined case with ovf = 0.

Test Plan (REFRESH_DIV = 4, GUARD = 1):
- Reset release, no load:
  - an4 low for 4 cycles with seg = 1000000; an3 low for 4 cycles with seg = 7F.
  - Exactly 1 cycle with both anodes high between the digit slots.
  - Frame period = 10 cycles.
- Load 4'b1011 (-5) mid-DIG_MAG:
  - ready = 0 until the next boundary; then value_q = 1011, ready = 1.
  - Next frame: DIG_MAG seg = 0010010, DIG_SIGN seg = 0111111.
- Load 4'b1000:
  - Magnitude slot shows 0000000 (digit 8); sign slot shows "-".
- Two loads (0011, then 0110) within one frame:
  - Boundary shows 6 (0000010); 3 is never displayed; sign digit blank.
- Load 0111 on the exact boundary cycle:
  - value_q = 0111 on the next cycle with no pending phase; glyph 1111000.
- Assert rst mid-DIG_SIGN with a pending load:
  - Outputs go immediately to seg = 7F, an3 = an4 = 1, ready = 1, value_q = 0.
  - After release, scanning restarts from GAP_M.
- With SEG_OVF_BLINK_EN defined, load 0101 with ovf = 1:
  - Digits are dark for 16 frames out of every 32.
